// File: rtl/scr1_dbgc_hart_cmd_seq.sv
// DBGC-side hart command sequencer: host halt/run strobes become a level req/ack/nack
// handshake with a local watchdog, plus instruction and debug data register staging.
module scr1_dbgc_hart_cmd_seq #(
  parameter int SCR1_DBGC_CMD_WDOG              = 256,
  parameter int SCR1_DBGC_DBG_CORE_INSTR_WIDTH  = 32,
  parameter int SCR1_DBGC_DBG_DATA_REG_WIDTH    = 32
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic                                       host_cmd_vld,
  input  logic                                       host_cmd,
  output logic                                       host_cmd_rdy,
  output logic [1:0]                                 host_cmd_sts,
  output logic                                       host_cmd_done,
  input  logic                                       host_instr_we,
  input  logic [SCR1_DBGC_DBG_CORE_INSTR_WIDTH-1:0]  host_instr,
  input  logic                                       host_ddr_we,
  input  logic [SCR1_DBGC_DBG_DATA_REG_WIDTH-1:0]    host_ddr_wdata,
  input  logic                                       host_ddr_rd,
  output logic [SCR1_DBGC_DBG_DATA_REG_WIDTH-1:0]    host_ddr_rdata,
  output logic                                       host_ddr_full,
  output logic                                       dbgc_hart_cmd,
  output logic                                       dbgc_hart_cmd_req,
  input  logic                                       dbgc_hart_cmd_ack,
  input  logic                                       dbgc_hart_cmd_nack,
  output logic [SCR1_DBGC_DBG_CORE_INSTR_WIDTH-1:0]  dbgc_hart_instr,
  output logic [SCR1_DBGC_DBG_DATA_REG_WIDTH-1:0]    dbgc_hart_dreg_out,
  input  logic [SCR1_DBGC_DBG_DATA_REG_WIDTH-1:0]    dbgc_hart_dreg_in,
  input  logic                                       dbgc_hart_dreg_wr
);

  localparam int IW     = SCR1_DBGC_DBG_CORE_INSTR_WIDTH;
  localparam int DW     = SCR1_DBGC_DBG_DATA_REG_WIDTH;
  localparam int WDOG_W = $clog2(SCR1_DBGC_CMD_WDOG);
  localparam logic [WDOG_W-1:0] WDOG_INIT = WDOG_W'(SCR1_DBGC_CMD_WDOG - 1);

  localparam logic MODE_RUN = 1'b0;

  localparam logic [1:0] STS_NONE  = 2'b00;
  localparam logic [1:0] STS_ACK   = 2'b01;
  localparam logic [1:0] STS_NACK  = 2'b10;
  localparam logic [1:0] STS_ABORT = 2'b11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic              cmd_q, cmd_d;
  logic [WDOG_W-1:0] wdog_q, wdog_d;
  logic [1:0]        sts_q, sts_d;
  logic              done_q, done_d;
  logic [IW-1:0]     instr_q, instr_d;
  logic [DW-1:0]     dreg_out_q, dreg_out_d;
  logic [DW-1:0]     ddr_rdata_q, ddr_rdata_d;
  logic              ddr_full_q, ddr_full_d;

  // Ack has priority over nack (hart halt-timeout reports both), and both over the watchdog.
  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    wdog_d  = wdog_q;
    sts_d   = sts_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (host_cmd_vld) begin
          state_d = ST_REQ;
          cmd_d   = host_cmd;
          wdog_d  = WDOG_INIT;
        end
      end
      ST_REQ: begin
        if (dbgc_hart_cmd_ack) begin
          state_d = ST_IDLE;
          sts_d   = STS_ACK;
          done_d  = 1'b1;
        end else if (dbgc_hart_cmd_nack) begin
          state_d = ST_IDLE;
          sts_d   = STS_NACK;
          done_d  = 1'b1;
        end else if (wdog_q == '0) begin
          state_d = ST_IDLE;
          sts_d   = STS_ABORT;
          done_d  = 1'b1;
        end else begin
          wdog_d = wdog_q - WDOG_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A core DDR write in the same cycle as a host read wins, so no fresh value is lost.
  always_comb begin
    instr_d     = host_instr_we ? host_instr     : instr_q;
    dreg_out_d  = host_ddr_we   ? host_ddr_wdata : dreg_out_q;
    ddr_rdata_d = ddr_rdata_q;
    ddr_full_d  = ddr_full_q;
    if (dbgc_hart_dreg_wr) begin
      ddr_rdata_d = dbgc_hart_dreg_in;
      ddr_full_d  = 1'b1;
    end else if (host_ddr_rd) begin
      ddr_full_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cmd_q       <= MODE_RUN;
      wdog_q      <= WDOG_INIT;
      sts_q       <= STS_NONE;
      done_q      <= 1'b0;
      instr_q     <= '0;
      dreg_out_q  <= '0;
      ddr_rdata_q <= '0;
      ddr_full_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      wdog_q      <= wdog_d;
      sts_q       <= sts_d;
      done_q      <= done_d;
      instr_q     <= instr_d;
      dreg_out_q  <= dreg_out_d;
      ddr_rdata_q <= ddr_rdata_d;
      ddr_full_q  <= ddr_full_d;
    end
  end

  assign host_cmd_rdy       = (state_q == ST_IDLE);
  assign dbgc_hart_cmd_req  = (state_q == ST_REQ);
  assign dbgc_hart_cmd      = cmd_q;
  assign host_cmd_sts       = sts_q;
  assign host_cmd_done      = done_q;
  assign dbgc_hart_instr    = instr_q;
  assign dbgc_hart_dreg_out = dreg_out_q;
  assign host_ddr_rdata     = ddr_rdata_q;
  assign host_ddr_full      = ddr_full_q;

endmodule

// File: tb/tb_scr1_dbgc_hart_cmd_seq.sv
// Randomized scoreboard bench for scr1_dbgc_hart_cmd_seq: each issued command pushes its
// expected status and req duration; a negedge monitor pops them when done pulses.
module tb_scr1_dbgc_hart_cmd_seq;

  localparam int WDOG = 256;

  logic        clk;
  logic        rst_n;
  logic        host_cmd_vld;
  logic        host_cmd;
  logic        host_cmd_rdy;
  logic [1:0]  host_cmd_sts;
  logic        host_cmd_done;
  logic        host_instr_we;
  logic [31:0] host_instr;
  logic        host_ddr_we;
  logic [31:0] host_ddr_wdata;
  logic        host_ddr_rd;
  logic [31:0] host_ddr_rdata;
  logic        host_ddr_full;
  logic        dbgc_hart_cmd;
  logic        dbgc_hart_cmd_req;
  logic        dbgc_hart_cmd_ack;
  logic        dbgc_hart_cmd_nack;
  logic [31:0] dbgc_hart_instr;
  logic [31:0] dbgc_hart_dreg_out;
  logic [31:0] dbgc_hart_dreg_in;
  logic        dbgc_hart_dreg_wr;

  scr1_dbgc_hart_cmd_seq #(
    .SCR1_DBGC_CMD_WDOG             (WDOG),
    .SCR1_DBGC_DBG_CORE_INSTR_WIDTH (32),
    .SCR1_DBGC_DBG_DATA_REG_WIDTH   (32)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .host_cmd_vld       (host_cmd_vld),
    .host_cmd           (host_cmd),
    .host_cmd_rdy       (host_cmd_rdy),
    .host_cmd_sts       (host_cmd_sts),
    .host_cmd_done      (host_cmd_done),
    .host_instr_we      (host_instr_we),
    .host_instr         (host_instr),
    .host_ddr_we        (host_ddr_we),
    .host_ddr_wdata     (host_ddr_wdata),
    .host_ddr_rd        (host_ddr_rd),
    .host_ddr_rdata     (host_ddr_rdata),
    .host_ddr_full      (host_ddr_full),
    .dbgc_hart_cmd      (dbgc_hart_cmd),
    .dbgc_hart_cmd_req  (dbgc_hart_cmd_req),
    .dbgc_hart_cmd_ack  (dbgc_hart_cmd_ack),
    .dbgc_hart_cmd_nack (dbgc_hart_cmd_nack),
    .dbgc_hart_instr    (dbgc_hart_instr),
    .dbgc_hart_dreg_out (dbgc_hart_dreg_out),
    .dbgc_hart_dreg_in  (dbgc_hart_dreg_in),
    .dbgc_hart_dreg_wr  (dbgc_hart_dreg_wr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] sts;
    int         len;
    logic       cmd;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   run_len = 0;
  logic done_prev = 1'b0;
  logic [1:0] last_sts = 2'b00;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: counts req-high cycles and checks each completion against the scoreboard.
  always @(negedge clk) begin
    if (!rst_n) begin
      run_len   = 0;
      done_prev = 1'b0;
      last_sts  = 2'b00;
    end else begin
      if (dbgc_hart_cmd_req) begin
        run_len++;
        if (exp_q.size() > 0) checkOutput("hart_cmd_stable", 32'(dbgc_hart_cmd), 32'(exp_q[0].cmd));
        else checkOutput("req_without_cmd", 32'(dbgc_hart_cmd_req), 32'd0);
      end
      if (host_cmd_done) begin
        checkOutput("done_single_cycle", 32'(done_prev), 32'd0);
        if (exp_q.size() == 0) begin
          checkOutput("spurious_done", 32'(host_cmd_done), 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          checkOutput("cmd_status", 32'(host_cmd_sts), 32'(e.sts));
          checkOutput("req_cycles", 32'(run_len), 32'(e.len));
          last_sts = e.sts;
        end
        run_len = 0;
      end else begin
        checkOutput("sts_hold", 32'(host_cmd_sts), 32'(last_sts));
      end
      done_prev = host_cmd_done;
    end
  end

  // kind: 0 ack, 1 nack, 2 ack+nack, 3 no response; delay = req cycle carrying the response.
  task automatic applyStimulus(input logic cmd, input int kind, input int delay, input bit extra_vld);
    exp_t e;
    int   budget;
    budget = 0;
    while (!host_cmd_rdy && budget < 600) begin
      @(posedge clk); #1;
      budget++;
    end
    if (!host_cmd_rdy) begin
      checkOutput("rdy_wait_timeout", 32'(host_cmd_rdy), 32'd1);
      return;
    end
    e.cmd = cmd;
    if (kind == 3 || delay > WDOG) begin
      e.sts = 2'b11;
      e.len = WDOG;
    end else begin
      e.sts = (kind == 1) ? 2'b10 : 2'b01;
      e.len = delay;
    end
    exp_q.push_back(e);
    host_cmd_vld = 1'b1;
    host_cmd     = cmd;
    @(posedge clk); #1;
    host_cmd_vld = 1'b0;
    host_cmd     = 1'($urandom);
    for (int i = 1; i <= delay && i <= 300; i++) begin
      if (i == delay && kind != 3) begin
        dbgc_hart_cmd_ack  = (kind != 1);
        dbgc_hart_cmd_nack = (kind != 0);
      end
      if (extra_vld && i == 2 && delay >= 3) begin
        host_cmd_vld = 1'b1;
        host_cmd     = ~cmd;
      end
      @(posedge clk); #1;
      dbgc_hart_cmd_ack  = 1'b0;
      dbgc_hart_cmd_nack = 1'b0;
      host_cmd_vld       = 1'b0;
    end
    checkOutput("req_dropped", 32'(dbgc_hart_cmd_req), 32'd0);
    if (kind == 3) begin
      dbgc_hart_cmd_ack = 1'b1;
      @(posedge clk); #1;
      dbgc_hart_cmd_ack = 1'b0;
    end
  endtask

  task automatic checkReset();
    checkOutput("rst_rdy", 32'(host_cmd_rdy), 32'd1);
    checkOutput("rst_req", 32'(dbgc_hart_cmd_req), 32'd0);
    checkOutput("rst_sts", 32'(host_cmd_sts), 32'd0);
    checkOutput("rst_done", 32'(host_cmd_done), 32'd0);
    checkOutput("rst_hart_cmd", 32'(dbgc_hart_cmd), 32'd0);
    checkOutput("rst_ddr_full", 32'(host_ddr_full), 32'd0);
    checkOutput("rst_ddr_rdata", host_ddr_rdata, 32'd0);
    checkOutput("rst_instr", dbgc_hart_instr, 32'd0);
    checkOutput("rst_dreg_out", dbgc_hart_dreg_out, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [31:0] m_instr, m_dreg, m_rdata;
    logic        m_full;
    int          kind, delay;
    rst_n = 1'b0;
    host_cmd_vld = 1'b0; host_cmd = 1'b0;
    host_instr_we = 1'b0; host_instr = '0;
    host_ddr_we = 1'b0; host_ddr_wdata = '0; host_ddr_rd = 1'b0;
    dbgc_hart_cmd_ack = 1'b0; dbgc_hart_cmd_nack = 1'b0;
    dbgc_hart_dreg_in = '0; dbgc_hart_dreg_wr = 1'b0;
    repeat (3) @(posedge clk);
    #1 checkReset();
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkReset();

    applyStimulus(1'b1, 0, 6, 1'b0);
    applyStimulus(1'b0, 1, 1, 1'b0);
    applyStimulus(1'b1, 2, 4, 1'b0);
    applyStimulus(1'b0, 3, 300, 1'b0);
    applyStimulus(1'b1, 0, WDOG, 1'b0);
    applyStimulus(1'b0, 1, WDOG, 1'b1);
    applyStimulus(1'b1, 0, WDOG + 1, 1'b1);
    applyStimulus(1'b0, 0, 5, 1'b1);
    for (int n = 0; n < 14; n++) begin
      kind = int'($urandom_range(0, 3));
      if (kind == 3) delay = 257 + int'($urandom_range(0, 5));
      else if ($urandom_range(0, 1) == 0) delay = int'($urandom_range(1, 12));
      else delay = int'($urandom_range(250, 258));
      applyStimulus(1'($urandom), kind, delay, 1'($urandom));
    end

    // Register staging with a small abstract model.
    m_instr = '0; m_dreg = '0; m_rdata = '0; m_full = 1'b0;
    dbgc_hart_dreg_wr = 1'b1; dbgc_hart_dreg_in = 32'hDEADBEEF; host_ddr_rd = 1'b1;
    @(posedge clk); #1;
    dbgc_hart_dreg_wr = 1'b0; host_ddr_rd = 1'b0;
    checkOutput("ddr_wr_rd_data", host_ddr_rdata, 32'hDEADBEEF);
    checkOutput("ddr_wr_rd_full", 32'(host_ddr_full), 32'd1);
    host_ddr_rd = 1'b1;
    @(posedge clk); #1;
    host_ddr_rd = 1'b0;
    checkOutput("ddr_lone_rd_full", 32'(host_ddr_full), 32'd0);
    m_rdata = 32'hDEADBEEF;
    for (int n = 0; n < 40; n++) begin
      host_instr_we     = 1'($urandom);
      host_instr        = $urandom;
      host_ddr_we       = 1'($urandom);
      host_ddr_wdata    = $urandom;
      host_ddr_rd       = 1'($urandom);
      dbgc_hart_dreg_wr = 1'($urandom);
      dbgc_hart_dreg_in = $urandom;
      if (n % 8 == 3) begin
        host_cmd_vld = 1'b1;
        host_cmd     = 1'b1;
        exp_q.push_back('{sts: 2'b01, len: 1, cmd: 1'b1});
        dbgc_hart_cmd_ack = 1'b0;
      end
      if (n % 8 == 4) dbgc_hart_cmd_ack = 1'b1;
      @(posedge clk);
      if (host_instr_we) m_instr = host_instr;
      if (host_ddr_we) m_dreg = host_ddr_wdata;
      if (dbgc_hart_dreg_wr) begin
        m_rdata = dbgc_hart_dreg_in;
        m_full  = 1'b1;
      end else if (host_ddr_rd) begin
        m_full  = 1'b0;
      end
      #1;
      host_cmd_vld = 1'b0;
      dbgc_hart_cmd_ack = 1'b0;
      checkOutput("instr_reg", dbgc_hart_instr, m_instr);
      checkOutput("dreg_out", dbgc_hart_dreg_out, m_dreg);
      checkOutput("ddr_rdata", host_ddr_rdata, m_rdata);
      checkOutput("ddr_full", 32'(host_ddr_full), 32'(m_full));
    end
    host_instr_we = 1'b0; host_ddr_we = 1'b0; host_ddr_rd = 1'b0; dbgc_hart_dreg_wr = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset mid-request: req must fall without waiting for a clock edge.
    exp_q.push_back('{sts: 2'b11, len: 0, cmd: 1'b1});
    host_cmd_vld = 1'b1; host_cmd = 1'b1;
    @(posedge clk); #1;
    host_cmd_vld = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("req_before_reset", 32'(dbgc_hart_cmd_req), 32'd1);
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    checkReset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    applyStimulus(1'b1, 0, 3, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
